// File: rtl/calib_digit_scanner.sv
// ============================================================================
// Module   : calib_digit_scanner
// Brief    : Streaming first/last-digit extractor summing 10*first+last per line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calib_digit_scanner #(
  parameter int RESULT_W     = 64,
  parameter int LINE_CNT_W   = 16,
  parameter int ZERO_WORD_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  input  logic                  in_last,
  input  logic                  word_mode,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [RESULT_W-1:0]   result,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  overflow
);

  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_done = 1'b1;
  localparam int         c_num_words = 10;

  // Patterns are right-aligned in a 5-byte window; unused upper bytes are zero.
  function automatic logic [39:0] word_pat(input int idx);
    case (idx)
      0:       word_pat = {8'h00,  "zero"};
      1:       word_pat = {16'h00, "one"};
      2:       word_pat = {16'h00, "two"};
      3:       word_pat = "three";
      4:       word_pat = {8'h00,  "four"};
      5:       word_pat = {8'h00,  "five"};
      6:       word_pat = {16'h00, "six"};
      7:       word_pat = "seven";
      8:       word_pat = "eight";
      9:       word_pat = {8'h00,  "nine"};
      default: word_pat = '0;
    endcase
  endfunction

  function automatic logic [39:0] word_mask(input logic [39:0] pat);
    word_mask = '0;
    for (int b = 0; b < 5; b++) begin
      if (pat[8*b +: 8] != 8'h00) word_mask[8*b +: 8] = 8'hFF;
    end
  endfunction

  logic [0:0]            state_q, state_d;
  logic [3:0][7:0]       hist_q, hist_d;
  logic                  have_q, have_d;
  logic [3:0]            first_q, first_d;
  logic [3:0]            last_q, last_d;
  logic [RESULT_W-1:0]   sum_q, sum_d;
  logic [LINE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic [39:0]            w_window;
  logic [c_num_words-1:0] w_word_hit;
  logic                   w_word_any;
  logic [3:0]             w_word_val;
  logic                   w_accept;
  logic                   w_is_num;
  logic                   w_is_nl;
  logic                   w_digit_evt;
  logic [3:0]             w_digit_val;
  logic                   w_have_nx;
  logic [3:0]             w_first_nx;
  logic [3:0]             w_last_nx;
  logic [6:0]             w_pair;
  logic                   w_close;
  logic                   w_commit;
  logic [RESULT_W:0]      w_sum_ext;
  logic [LINE_CNT_W-1:0]  w_cnt_inc;

  assign w_window = {hist_q, in_char};

  // Suffix match of every word against history plus the current character.
  for (genvar gi = 0; gi < c_num_words; gi++) begin : g_word
    localparam logic [39:0] c_pat  = word_pat(gi);
    localparam logic [39:0] c_mask = word_mask(c_pat);
    localparam bit          c_en   = (gi != 0) || (ZERO_WORD_EN != 0);
    assign w_word_hit[gi] = c_en && ((w_window & c_mask) == c_pat);
  end

  always_comb begin
    w_word_any = 1'b0;
    w_word_val = 4'd0;
    for (int i = 0; i < c_num_words; i++) begin
      if (w_word_hit[i]) begin
        w_word_any = 1'b1;
        w_word_val = 4'(i);
      end
    end
  end

  always_comb begin
    w_accept    = in_valid && (state_q == c_st_run);
    w_is_num    = (in_char >= 8'h30) && (in_char <= 8'h39);
    w_is_nl     = (in_char == 8'h0A);
    w_digit_evt = w_is_num || (word_mode && w_word_any);
    w_digit_val = w_is_num ? in_char[3:0] : w_word_val;
    w_have_nx   = have_q || w_digit_evt;
    w_first_nx  = (w_digit_evt && !have_q) ? w_digit_val : first_q;
    w_last_nx   = w_digit_evt ? w_digit_val : last_q;
    w_pair      = {w_first_nx, 3'b000} + {2'b00, w_first_nx, 1'b0} + {3'b000, w_last_nx};
    w_close     = w_is_nl || in_last;
    w_commit    = w_close && w_have_nx;
    w_sum_ext   = {1'b0, sum_q} + {{(RESULT_W-6){1'b0}}, w_pair};
    w_cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + LINE_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_run;
      hist_q  <= '0;
      have_q  <= 1'b0;
      first_q <= 4'd0;
      last_q  <= 4'd0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      have_q  <= have_d;
      first_q <= first_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_run:  if (w_accept && in_last) state_d = c_st_done;
      c_st_done: if (result_ready)        state_d = c_st_run;
      default:                            state_d = c_st_run;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == c_st_run);
    result_valid = (state_q == c_st_done);
  end

  always_comb begin
    hist_d  = hist_q;
    have_d  = have_q;
    first_d = first_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (state_q == c_st_run) begin
      if (w_accept) begin
        if (w_commit) begin
          sum_d = w_sum_ext[RESULT_W-1:0];
          ovf_d = ovf_q | w_sum_ext[RESULT_W];
          cnt_d = w_cnt_inc;
        end
        // Line state also closes on in_last; the handshake clears it anyway.
        if (w_close) begin
          hist_d  = '0;
          have_d  = 1'b0;
          first_d = 4'd0;
          last_d  = 4'd0;
        end else begin
          hist_d  = {hist_q[2:0], in_char};
          have_d  = w_have_nx;
          first_d = w_first_nx;
          last_d  = w_last_nx;
        end
      end
    end else if (result_ready) begin
      hist_d  = '0;
      have_d  = 1'b0;
      first_d = 4'd0;
      last_d  = 4'd0;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  assign result     = sum_q;
  assign line_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_calib_digit_scanner.sv
// ============================================================================
// Module   : tb_calib_digit_scanner
// Brief    : Table-driven bench for calib_digit_scanner across three configs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calib_digit_scanner;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_last;
  logic        word_mode;
  logic        result_ready;

  logic        rdy_a, rdy_z, rdy_n;
  logic        val_a, val_z, val_n;
  logic [63:0] res_a, res_z;
  logic [7:0]  res_n;
  logic [15:0] cnt_a, cnt_z;
  logic [1:0]  cnt_n;
  logic        ovf_a, ovf_z, ovf_n;

  int n_pass  = 0;
  int n_total = 0;

  calib_digit_scanner u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_char(in_char),
    .in_last(in_last), .word_mode(word_mode), .result_valid(val_a),
    .result_ready(result_ready), .result(res_a), .line_count(cnt_a), .overflow(ovf_a)
  );

  calib_digit_scanner #(.ZERO_WORD_EN(1)) u_dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_z), .in_char(in_char),
    .in_last(in_last), .word_mode(word_mode), .result_valid(val_z),
    .result_ready(result_ready), .result(res_z), .line_count(cnt_z), .overflow(ovf_z)
  );

  calib_digit_scanner #(.RESULT_W(8), .LINE_CNT_W(2)) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_n), .in_char(in_char),
    .in_last(in_last), .word_mode(word_mode), .result_valid(val_n),
    .result_ready(result_ready), .result(res_n), .line_count(cnt_n), .overflow(ovf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string text;
    bit    wm;
    int    res;
    int    cnt;
    int    res_z;
    int    cnt_z;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Entered just after a falling edge; returns just after the next one.
  task automatic send(input logic [7:0] c, input bit last, input bit wm);
    int guard;
    in_valid  = 1'b1;
    in_char   = c;
    in_last   = last;
    word_mode = wm;
    guard = 0;
    while (!(rdy_a && rdy_z && rdy_n) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_stream(input string s, input bit wm);
    for (int i = 0; i < s.len(); i++) send(s[i], (i == s.len() - 1), wm);
  endtask

  task automatic expect_result(input string name, input int ra, input int ca,
                               input int rz, input int cz);
    int cn;
    cn = (ca > 3) ? 3 : ca;
    check({name, ".valid_a"}, 64'(val_a), 64'd1);
    check({name, ".valid_z"}, 64'(val_z), 64'd1);
    check({name, ".valid_n"}, 64'(val_n), 64'd1);
    check({name, ".in_ready"}, 64'(rdy_a), 64'd0);
    check({name, ".res_a"}, res_a, 64'(ra));
    check({name, ".cnt_a"}, 64'(cnt_a), 64'(ca));
    check({name, ".ovf_a"}, 64'(ovf_a), 64'd0);
    check({name, ".res_z"}, res_z, 64'(rz));
    check({name, ".cnt_z"}, 64'(cnt_z), 64'(cz));
    check({name, ".res_n"}, 64'(res_n), 64'(ra % 256));
    check({name, ".cnt_n"}, 64'(cnt_n), 64'(cn));
    check({name, ".ovf_n"}, 64'(ovf_n), 64'(ra > 255));
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vecs[0]  = '{"two1nine\neightwothree\nzoneight234\n", 1'b1, 126, 3, 126, 3};
    vecs[1]  = '{"eightwo", 1'b1, 82, 1, 82, 1};
    vecs[2]  = '{"zero\nzero5\n", 1'b1, 55, 1, 5, 2};
    vecs[3]  = '{"1abc2\ntreb7uchet\ntwo1nine\n", 1'b0, 100, 3, 100, 3};
    vecs[4]  = '{"abc\nx9y\n", 1'b0, 99, 1, 99, 1};
    vecs[5]  = '{"99\n99\n99\n", 1'b1, 297, 3, 297, 3};
    vecs[6]  = '{"\015\nsevenine\015\n", 1'b1, 79, 1, 79, 1};
    vecs[7]  = '{"thr\nee1\n", 1'b1, 11, 1, 11, 1};
    vecs[8]  = '{"nineight5\n", 1'b1, 95, 1, 95, 1};
    vecs[9]  = '{"onetwo3four\n", 1'b0, 33, 1, 33, 1};
    vecs[10] = '{"ONE7\n", 1'b1, 77, 1, 77, 1};
    vecs[11] = '{"1\n2\n3\n4\n5\n", 1'b0, 165, 5, 165, 5};

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0;
    word_mode = 1'b0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.result", res_a, 64'd0);
    check("reset.line_count", 64'(cnt_a), 64'd0);
    check("reset.overflow", 64'(ovf_a), 64'd0);
    check("reset.result_valid", 64'(val_a), 64'd0);
    check("reset.in_ready", 64'(rdy_a), 64'd1);
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      run_stream(vecs[v].text, vecs[v].wm);
      expect_result($sformatf("vec%0d", v), vecs[v].res, vecs[v].cnt,
                    vecs[v].res_z, vecs[v].cnt_z);
      handshake();
    end

    // Result held while consumer stalls, offered beats must not be consumed.
    run_stream("42\n", 1'b0);
    in_valid = 1'b1; in_char = "7"; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.in_ready", k), 64'(rdy_a), 64'd0);
      check($sformatf("stall%0d.result", k), res_a, 64'd42);
      check($sformatf("stall%0d.valid", k), 64'(val_a), 64'd1);
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("post_hs.in_ready", 64'(rdy_a), 64'd1);
    check("post_hs.valid", 64'(val_a), 64'd0);
    check("post_hs.result", res_a, 64'd0);
    @(negedge clk);
    send("\n", 1'b1, 1'b0);
    expect_result("restart", 77, 1, 77, 1);
    handshake();

    // Asynchronous reset mid-stream discards the partial sum and open line.
    send("1", 1'b0, 1'b0);
    send("2", 1'b0, 1'b0);
    send("\n", 1'b0, 1'b0);
    send("3", 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst.result", res_a, 64'd0);
    check("async_rst.line_count", 64'(cnt_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_stream("5\n", 1'b0);
    expect_result("after_rst", 55, 1, 55, 1);
    handshake();

    // Idle cycles with garbage on the bus leave state untouched.
    send("4", 1'b0, 1'b0);
    in_valid = 1'b0; in_char = "8"; in_last = 1'b1;
    repeat (3) @(negedge clk);
    check("gap.in_ready", 64'(rdy_a), 64'd1);
    check("gap.valid", 64'(val_a), 64'd0);
    send("2", 1'b0, 1'b0);
    send("\n", 1'b1, 1'b0);
    expect_result("gaps", 42, 1, 42, 1);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calib_digit_scanner.md
# calib_digit_scanner

Streaming solver for calibration-value extraction, a parametrised successor to the single-purpose day-1 part-2 solver. It consumes one ASCII character per beat and finds the first and last digit of each line. Digits may be numerals, or spelled-out words when word mode is enabled, and overlapping words are recognised. It accumulates `10*first + last` per line into a configurable-width sum and returns that sum and a line count through a ready/valid result port at end of stream.

## Interface
- `RESULT_W`, 64: accumulator/result width; sum wraps modulo 2^RESULT_W.
- `LINE_CNT_W`, 16: width of counted-line register; saturates at all-ones.
- `ZERO_WORD_EN`, 0: 1 = the word "zero" is also recognised as digit 0.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  character beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_char`  in  8  ASCII character.
- `in_last`  in  1  qualifies the final beat of the stream.
- `word_mode`  in  1  1 = spelled words count as digits; sampled per accepted beat.
- `result_valid`  out  1  final result available.
- `result_ready`  in  1  consumer accepts result.
- `result`  out  RESULT_W  final sum.
- `line_count`  out  LINE_CNT_W  lines that contained at least one digit.
- `overflow`  out  1  sticky; sum wrapped at least once this stream.

## Operation
- Beat accepted when `in_valid && in_ready`. `in_ready = !result_valid`; combinational, no dependency on `in_valid`.
- History: 4-entry shift register of the previous accepted characters on the current line. Every accepted non-newline character shifts in. A newline clears history to 0x00.
- Word detection uses a suffix match: the word ending at the current character is compared against history plus current char. Words: one two three four five six seven eight nine (plus zero if `ZERO_WORD_EN`). Lowercase only.
- Because detection is suffix-based with no state reset on a match, overlapping words are all found. Example: "eightwo" yields 8 then 2.
- Digit event on a beat: `in_char` in 0x30–0x39 gives value `in_char-0x30`. Otherwise, if `word_mode=1` and a word suffix matches, the value is that word's digit. At most one word can end on a given character.
- Line state: `have_digit`, `first[3:0]`, `last[3:0]`.
  - Digit event while `!have_digit`: set first=last=value, set have_digit.
  - Digit event while `have_digit`: set last=value.
- Newline (0x0A):
  - If have_digit (including a digit event on this beat, which cannot occur for 0x0A): sum += 10*first+last, line_count += 1 (saturating).
  - If not have_digit: line contributes 0 and is not counted.
  - Either way, line state and history clear.
- 0x0D and all other characters: shift into history only.
- `in_last` beat: the character is processed normally. If the line is still open with have_digit after that character, it is finalised as if a newline followed. Then `result_valid` is set.
- Arithmetic: 10*first+last computed in 7 bits, zero-extended to RESULT_W. The carry out of the RESULT_W-bit add sets `overflow`.
- Result handshake: `result`, `line_count` and `overflow` hold stable while `result_valid=1`. On `result_valid && result_ready`:
  - result_valid clears;
  - sum, line_count, overflow, history and line state clear;
  - the next stream may start the following cycle.
- State machine:
  - RUN: accepting beats. Goes to DONE on accepted `in_last`.
  - DONE: `result_valid=1`. Goes to RUN on result handshake.

## Timing
- Reset values: result 0, line_count 0, overflow 0, result_valid 0, in_ready 1 (first cycle after `rst` deasserts). History, line state and FSM go to RUN with everything cleared.
- Per-line sum is visible in internal state the cycle after the newline beat. `result` is not valid until DONE.
- Final latency: `result_valid` rises on the clock edge that accepts the `in_last` beat and is visible the next cycle. The value includes that beat.
- `in_ready` is low for every DONE cycle. Beats offered then are not consumed, and `in_valid` may stay high.
- Back-to-back streams: the minimum gap between an `in_last` beat and the first beat of the next stream is 2 cycles with `result_ready` held high.
- `rst` mid-stream or in DONE: immediate return to reset values; the partial sum is discarded.
- `in_valid` low cycles: no state change.

## Test plan
- word_mode=1, "two1nine\n" "eightwothree\n" "zoneight234\n" with last set on the final '\n' -> result 29+83+14=126, line_count 3, overflow 0.
- word_mode=1, "eightwo" with in_last on 'o' (no newline) -> result 82, line_count 1; with ZERO_WORD_EN=0, "zero5\n" -> 55.
- word_mode=0, "1abc2\n" "treb7uchet\n" "two1nine\n" (last) -> 12+77+11=100, line_count 3.
- "abc\n" "x9y\n" (last) -> result 99, line_count 1 (empty line uncounted).
- RESULT_W=8: "99\n" x3 (last on final '\n') -> result 297 mod 256 = 41, overflow 1, line_count 3.
- Hold result_ready low 5 cycles with in_valid high -> in_ready 0, result stable, no beats consumed. Then assert result_ready -> next stream's first beat is accepted 1 cycle after the handshake and accumulates from 0.
